// File: rtl/ni_pkg.sv
// Shared definitions for the network receive interface.
// Holds the register offsets, the STATUS bit positions and the read-FSM state type.
package ni_pkg;

  // Register offsets, selected by addr_cpu[3:2]
  localparam logic [1:0] NI_RX_STATUS    = 2'd0;
  localparam logic [1:0] NI_RX_HEAD_ADDR = 2'd1;
  localparam logic [1:0] NI_RX_HEAD_DATA = 2'd2;
  localparam logic [1:0] NI_RX_DROP_CNT  = 2'd3;

  // STATUS register bit positions
  localparam int NI_RX_ST_NONEMPTY  = 0;
  localparam int NI_RX_ST_OVERFLOW  = 1;
  localparam int NI_RX_ST_FULL      = 2;
  localparam int NI_RX_ST_COUNT_LSB = 8;

  // Read FSM states
  typedef enum logic [1:0] {
    RX_EMPTY,
    RX_AVAIL,
    RX_LATCHED
  } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous 64-bit receive FIFO with push/pop, occupancy count and full/empty flags.
// The head entry is presented combinationally. A push is accepted when full as long
// as a pop happens in the same cycle.
module rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [63:0]              din,
  output logic [63:0]              head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage write; entries carry no reset value
  // NOTE: the memory array is deliberately left out of reset; stale entries are never
  // visible because count gates every read, and skipping reset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at power-of-two DEPTH
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rptr];
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

endmodule

// File: rtl/network_rx_interface.sv
// Receive-side network interface: the router pushes {addr, data} packets into a local
// FIFO and the CPU pops them through a 4-register memory-mapped window.
// Optional feature macro: NI_RX_DROP_COUNT_EN builds a 16-bit saturating drop counter.
module network_rx_interface
  import ni_pkg::*;
#(
  parameter int          DEPTH     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_1010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] data_out_rauter,
  input  logic        write_en_rauter,
  output logic        rauter_ready,
  input  logic [31:0] addr_cpu,
  input  logic        read_en_cpu,
  output logic [31:0] data_in_cpu,
  output logic        rx_irq,
  output logic        debug_fifo_overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  rx_state_e     state;
  logic [63:0]   hold;
  logic [63:0]   head;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          full;
  logic          empty;
  logic          hit;
  logic [1:0]    offset;
  logic [31:0]   status_word;
  logic [31:0]   read_value;
  logic          pop;
  logic          latch;
  logic          status_read;
  logic          drop_read;
  logic          push_ok;
  logic          drop;
  logic [15:0]   drop_cnt;
  logic          unused_bits;

  rx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .din   (data_out_rauter),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign hit          = (addr_cpu[31:4] == BASE_ADDR[31:4]);
  assign offset       = addr_cpu[3:2];
  assign push_ok      = write_en_rauter && (!full || pop);
  assign drop         = write_en_rauter && full && !pop;
  assign rauter_ready = !full;
  assign rx_irq       = !empty;

  // STATUS word assembly
  always_comb begin
    status_word = '0;
    status_word[NI_RX_ST_NONEMPTY] = !empty;
    status_word[NI_RX_ST_OVERFLOW] = debug_fifo_overflow;
    status_word[NI_RX_ST_FULL]     = full;
    status_word[NI_RX_ST_COUNT_LSB +: 8] = 8'(count);
  end

  // Register decode: read data and the side effects of this access
  // NOTE: every output of this block gets a default first so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    read_value  = '0;
    pop         = 1'b0;
    latch       = 1'b0;
    status_read = 1'b0;
    drop_read   = 1'b0;
    if (read_en_cpu && hit) begin
      case (offset)
        NI_RX_STATUS: begin
          read_value  = status_word;
          status_read = 1'b1;
        end
        NI_RX_HEAD_ADDR: begin
          if (state != RX_EMPTY) begin
            read_value = head[63:32];
            latch      = 1'b1;
          end
        end
        NI_RX_HEAD_DATA: begin
          if (state == RX_AVAIL) begin
            read_value = head[31:0];
            pop        = 1'b1;
          end else if (state == RX_LATCHED) begin
            read_value = hold[31:0];
            pop        = 1'b1;
          end
        end
        default: begin
          read_value = {16'h0000, drop_cnt};
          drop_read  = 1'b1;
        end
      endcase
    end
  end

  // Occupancy after this edge, including any same-cycle push
  always_comb begin
    count_next = count;
    case ({push_ok, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Read FSM with registered read data, hold register and sticky overflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= RX_EMPTY;
      hold                <= '0;
      data_in_cpu         <= '0;
      debug_fifo_overflow <= 1'b0;
    end else begin
      if (read_en_cpu) data_in_cpu <= read_value;
      if (latch)       hold        <= head;

      // A drop in the same cycle as a STATUS read keeps the flag set
      if (drop)             debug_fifo_overflow <= 1'b1;
      else if (status_read) debug_fifo_overflow <= 1'b0;

      if (pop)                                state <= (count_next != '0) ? RX_AVAIL : RX_EMPTY;
      else if (latch)                         state <= RX_LATCHED;
      else if (state == RX_EMPTY && push_ok)  state <= RX_AVAIL;
    end
  end

`ifdef NI_RX_DROP_COUNT_EN
  // Saturating count of rejected pushes, cleared by a DROP_CNT read
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop_read) begin
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign unused_bits = ^{addr_cpu[1:0], hold[63:32]};
`else
  assign drop_cnt    = '0;
  assign unused_bits = ^{addr_cpu[1:0], hold[63:32], drop_read};
`endif

endmodule

// File: tb/tb_network_rx_interface.sv
// Directed testbench for network_rx_interface (DEPTH=16, BASE_ADDR=0x1010).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_network_rx_interface;

  localparam logic [31:0] A_STATUS = 32'h0000_1010;
  localparam logic [31:0] A_HADDR  = 32'h0000_1014;
  localparam logic [31:0] A_HDATA  = 32'h0000_1018;
  localparam logic [31:0] A_DROP   = 32'h0000_101C;
  localparam logic [31:0] A_OUTSIDE = 32'h0000_1030;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] data_out_rauter;
  logic        write_en_rauter;
  logic        rauter_ready;
  logic [31:0] addr_cpu;
  logic        read_en_cpu;
  logic [31:0] data_in_cpu;
  logic        rx_irq;
  logic        debug_fifo_overflow;

  int checks = 0;
  int errors = 0;

  network_rx_interface #(.DEPTH(16), .BASE_ADDR(32'h0000_1010)) dut (
    .clk                 (clk),
    .reset               (reset),
    .data_out_rauter     (data_out_rauter),
    .write_en_rauter     (write_en_rauter),
    .rauter_ready        (rauter_ready),
    .addr_cpu            (addr_cpu),
    .read_en_cpu         (read_en_cpu),
    .data_in_cpu         (data_in_cpu),
    .rx_irq              (rx_irq),
    .debug_fifo_overflow (debug_fifo_overflow)
  );

  always #5 clk = ~clk;

  task automatic push_pkt(input logic [63:0] p);
    @(negedge clk);
    data_out_rauter = p;
    write_en_rauter = 1'b1;
    @(negedge clk);
    write_en_rauter = 1'b0;
  endtask

  task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_cpu    = a;
    read_en_cpu = 1'b1;
    @(negedge clk);
    read_en_cpu = 1'b0;
    d = data_in_cpu;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    write_en_rauter = 1'b0;
    read_en_cpu = 1'b0;
    data_out_rauter = '0;
    addr_cpu = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if (rauter_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", rauter_ready); end
    checks++;
    if (rx_irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", rx_irq); end
    checks++;
    if (debug_fifo_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", debug_fifo_overflow); end
    checks++;
    if (data_in_cpu !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_in_cpu); end
  endtask

  task automatic test_single;
    logic [31:0] d;
    push_pkt({32'h0000_0040, 32'hDEAD_BEEF});
    checks++;
    if (rx_irq !== 1'b1) begin errors++; $display("FAIL single_irq: got %b expected 1", rx_irq); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0101) begin errors++; $display("FAIL single_status: got %h expected 00000101", d); end
    cpu_read(A_HADDR, d);
    checks++;
    if (d !== 32'h0000_0040) begin errors++; $display("FAIL single_haddr: got %h expected 00000040", d); end
    cpu_read(A_HDATA, d);
    checks++;
    if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_hdata: got %h expected deadbeef", d); end
    checks++;
    if (rx_irq !== 1'b0) begin errors++; $display("FAIL single_irq_clr: got %b expected 0", rx_irq); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL single_status_clr: got %h expected 0", d); end
  endtask

  // Two full fill/drain rounds; the second starts with pointers at a nonzero position
  task automatic test_fill_drain;
    logic [31:0] d;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) push_pkt({32'h0000_0100 + 32'(i), 32'(i)});
      checks++;
      if (rauter_ready !== 1'b0) begin errors++; $display("FAIL fill_ready r%0d: got %b expected 0", r, rauter_ready); end
      cpu_read(A_STATUS, d);
      checks++;
      if (d !== 32'h0000_1005) begin errors++; $display("FAIL fill_status r%0d: got %h expected 00001005", r, d); end
      // Back-to-back HEAD_DATA reads: each cycle sees the next head
      @(negedge clk);
      addr_cpu    = A_HDATA;
      read_en_cpu = 1'b1;
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        checks++;
        if (data_in_cpu !== 32'(i)) begin errors++; $display("FAIL drain r%0d[%0d]: got %h expected %h", r, i, data_in_cpu, 32'(i)); end
      end
      read_en_cpu = 1'b0;
      cpu_read(A_STATUS, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL drain_status r%0d: got %h expected 0", r, d); end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] d;
    for (int i = 0; i < 16; i++) push_pkt({32'h0000_0200, 32'(i)});
    push_pkt({32'h0000_0300, 32'h0000_00FF});
    checks++;
    if (debug_fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", debug_fifo_overflow); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_1007) begin errors++; $display("FAIL ovf_status1: got %h expected 00001007", d); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_1005) begin errors++; $display("FAIL ovf_status2: got %h expected 00001005", d); end
    cpu_read(A_DROP, d);
`ifdef NI_RX_DROP_COUNT_EN
    checks++;
    if (d !== 32'h1) begin errors++; $display("FAIL drop_cnt1: got %h expected 1", d); end
`else
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL drop_cnt1: got %h expected 0", d); end
`endif
    cpu_read(A_DROP, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL drop_cnt2: got %h expected 0", d); end
  endtask

  // FIFO is full with payloads 0..15 on entry
  task automatic test_full_push_pop;
    logic [31:0] d;
    @(negedge clk);
    addr_cpu        = A_HDATA;
    read_en_cpu     = 1'b1;
    data_out_rauter = {32'h0000_01AA, 32'h0000_00AA};
    write_en_rauter = 1'b1;
    @(negedge clk);
    read_en_cpu     = 1'b0;
    write_en_rauter = 1'b0;
    checks++;
    if (data_in_cpu !== 32'h0) begin errors++; $display("FAIL pp_data: got %h expected 0", data_in_cpu); end
    checks++;
    if (debug_fifo_overflow !== 1'b0) begin errors++; $display("FAIL pp_ovf: got %b expected 0", debug_fifo_overflow); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_1005) begin errors++; $display("FAIL pp_status: got %h expected 00001005", d); end
    for (int i = 1; i < 17; i++) begin
      cpu_read(A_HDATA, d);
      checks++;
      if (d !== ((i == 16) ? 32'h0000_00AA : 32'(i))) begin
        errors++; $display("FAIL pp_drain[%0d]: got %h expected %h", i, d, (i == 16) ? 32'h0000_00AA : 32'(i));
      end
    end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL pp_status_end: got %h expected 0", d); end
  endtask

  task automatic test_empty_and_window;
    logic [31:0] d;
    cpu_read(A_HDATA, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL empty_hdata: got %h expected 0", d); end
    cpu_read(A_HADDR, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL empty_haddr: got %h expected 0", d); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL empty_status: got %h expected 0", d); end
    push_pkt({32'h0000_0055, 32'h0000_0077});
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0101) begin errors++; $display("FAIL win_status1: got %h expected 00000101", d); end
    cpu_read(A_OUTSIDE, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL outside_read: got %h expected 0", d); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0101) begin errors++; $display("FAIL win_status2: got %h expected 00000101", d); end
  endtask

  // One packet pending on entry; latch it, then reset mid-transaction
  task automatic test_reset_mid;
    logic [31:0] d;
    cpu_read(A_HADDR, d);
    checks++;
    if (d !== 32'h0000_0055) begin errors++; $display("FAIL mid_haddr: got %h expected 00000055", d); end
    push_pkt({32'h0000_0066, 32'h0000_0088});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (data_in_cpu !== 32'h0) begin errors++; $display("FAIL mid_data: got %h expected 0", data_in_cpu); end
    checks++;
    if (rx_irq !== 1'b0) begin errors++; $display("FAIL mid_irq: got %b expected 0", rx_irq); end
    checks++;
    if (rauter_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", rauter_ready); end
    checks++;
    if (debug_fifo_overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", debug_fifo_overflow); end
    cpu_read(A_HDATA, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_hdata: got %h expected 0", d); end
    cpu_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL mid_status: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_empty_and_window();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/network_rx_interface.md
# network_rx_interface

Receive-side network interface: accepts 64-bit `{addr, data}` packets from the router into a local receive FIFO and exposes them to the CPU as memory-mapped 32-bit registers. It completes the CPU↔router path opposite the transmit buffer: the router pushes, and the CPU pops by reading. The block sits on the CPU data-memory bus beside the transmit interface and raises a level interrupt while packets are pending.

## Interface
Parameters:
- `DEPTH`, 16: receive FIFO entries; power of two, 2..128.
- `BASE_ADDR`, 32'h0000_1010: register window base, 16-byte aligned.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_out_rauter`  in  64  router packet; `[63:32]` source address, `[31:0]` payload.
- `write_en_rauter`  in  1  router push strobe, one packet per cycle.
- `rauter_ready`  out  1  FIFO can accept a packet; combinational, `count != DEPTH`.
- `addr_cpu`  in  32  CPU byte address.
- `read_en_cpu`  in  1  CPU read strobe, one cycle per access.
- `data_in_cpu`  out  32  registered read data.
- `rx_irq`  out  1  high while FIFO is non-empty.
- `debug_fifo_overflow`  out  1  sticky overflow flag.

## Operation
- Window hit: `addr_cpu[31:4] == BASE_ADDR[31:4]`. Offset `addr_cpu[3:2]` selects the register:
  - 0 STATUS: bit0 non-empty, bit1 overflow (sticky), bit2 full, `[15:8]` count, other bits 0.
  - 1 HEAD_ADDR: address word of the head packet.
  - 2 HEAD_DATA: payload of the head packet.
  - 3 DROP_CNT: see Configuration.
- Any read outside the window returns 0 and has no side effects.
- Read FSM states:
  - EMPTY (count 0): any read of HEAD_ADDR or HEAD_DATA returns 0, with no pop and no state change.
  - AVAIL: HEAD_ADDR read copies the head packet into a 64-bit hold register, returns `hold[63:32]`, and moves to LATCHED. HEAD_DATA read returns the head payload directly and pops.
  - LATCHED: HEAD_DATA read returns `hold[31:0]` and pops. HEAD_ADDR read re-latches the current head, which is the same packet.
  - After a pop, the state becomes AVAIL if the remaining count (including any same-cycle push) is nonzero, otherwise EMPTY.
- Push: when `write_en_rauter` is high, the packet is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave count unchanged.
  - A push that is not accepted is dropped. It sets overflow and increments DROP_CNT when that counter is compiled in.
- STATUS read returns the overflow flag, then clears it. An overflow in the same cycle wins, so the flag stays set.
- Pointers wrap modulo DEPTH. Count is `$clog2(DEPTH)+1` bits wide.

## Timing
- `data_in_cpu` is valid the cycle after `read_en_cpu` and holds until the next read.
- The pop takes effect at the same edge that registers the data. A back-to-back read next cycle sees the new head.
- A pushed packet is visible to the CPU (STATUS, `rx_irq`) the cycle after the push edge.
- Reset values, applied at any time including mid-packet:
  - count, pointers, and hold register: 0.
  - State: EMPTY.
  - `data_in_cpu`, `rx_irq`, `debug_fifo_overflow`, DROP_CNT: 0.
  - `rauter_ready`: 1.
  - FIFO contents are discarded.

## Configuration
- `NI_RX_DROP_COUNT_EN` defined: a 16-bit saturating DROP_CNT counts rejected pushes. Reading DROP_CNT returns it zero-extended and clears it. An increment in the same cycle leaves the value at 1.
- Macro undefined: no counter is built, and DROP_CNT reads 0. Overflow flag behaviour is unchanged.

## Structure
- Package `ni_pkg`:
  - register offsets: `NI_RX_STATUS`, `NI_RX_HEAD_ADDR`, `NI_RX_HEAD_DATA`, `NI_RX_DROP_CNT`;
  - STATUS bit positions;
  - read-FSM state enum `{RX_EMPTY, RX_AVAIL, RX_LATCHED}`.
- One sub-module, `rx_fifo`: a synchronous 64-bit FIFO with push/pop, count, full and empty outputs, and a combinational head output. It must support simultaneous push and pop when full.
- Decode, FSM, hold register and counters live in the top module.

## Test plan
- Push `{32'h0000_0040, 32'hDEAD_BEEF}`. Next cycle: `rx_irq=1`, STATUS reads `0x0000_0101`. Read HEAD_ADDR returns `0x40`, then HEAD_DATA returns `0xDEADBEEF`. After that, `rx_irq=0` and STATUS reads 0.
- Push DEPTH=16 packets with payloads 0..15. Check `rauter_ready=0` and STATUS bit2 set. Drain with HEAD_DATA reads and confirm payloads 0..15 in order; this also exercises pointer wrap on a second fill.
- When full, push once more: the packet is dropped, STATUS bit1 reads 1 and then 0 on a re-read. With `NI_RX_DROP_COUNT_EN`, DROP_CNT reads 1, then 0.
- When full, push and pop in the same cycle: count stays 16, and the new packet emerges last.
- Read HEAD_DATA when empty: returns 0 and count stays 0. Read at `BASE_ADDR+0x20`: returns 0 with no pop.
- Latch HEAD_ADDR, then assert `reset` for one cycle. Afterwards all outputs are at reset values and a HEAD_DATA read returns 0.
